// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I format codes, opcodes and immediate limits shared by encoder and decoder
package rv_pkg;

    localparam logic [2:0] RTYPE = 3'd0;
    localparam logic [2:0] ITYPE = 3'd1;
    localparam logic [2:0] STYPE = 3'd2;
    localparam logic [2:0] BTYPE = 3'd3;
    localparam logic [2:0] UTYPE = 3'd4;
    localparam logic [2:0] JTYPE = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } enc_word_t;

    function automatic logic in_span(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/rv_enc_pack.sv
// rtl/rv_enc_pack.sv - combinational RV32I field packer; ENC_RANGE_CHECK_EN enables immediate range checks
module rv_enc_pack
    import rv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        ok
);

    logic fmt_ok;
    logic range_ok;

    always_comb begin
        inst   = '0;
        fmt_ok = 1'b1;
        case (fmt)
            RTYPE:   inst = {funct7, rs2, rs1, funct3, rd, op};
            ITYPE:   inst = {imm[11:0], rs1, funct3, rd, op};
            STYPE:   inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            BTYPE:   inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            UTYPE:   inst = {imm[31:12], rd, op};
            JTYPE:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    always_comb begin
        range_ok = 1'b1;
        case (fmt)
            ITYPE, STYPE: range_ok = in_span(imm, IMM12_MIN, IMM12_MAX);
            BTYPE:        range_ok = in_span(imm, IMM_B_MIN, IMM_B_MAX) && !imm[0];
            JTYPE:        range_ok = in_span(imm, IMM_J_MIN, IMM_J_MAX) && !imm[0];
            UTYPE:        range_ok = (imm[11:0] == 12'd0);
            default:      range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    assign ok = fmt_ok && range_ok;

endmodule

// File: rtl/rv_inst_encoder.sv
// rtl/rv_inst_encoder.sv - streaming RV32I encoder with address tagging and output FIFO; honours ENC_RANGE_CHECK_EN
module rv_inst_encoder
    import rv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_op,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    input  logic        flush,
    output logic        err,
    input  logic        err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    enc_word_t   mem [FIFO_DEPTH];
    enc_word_t   head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] addr_cnt;
    logic [31:0] pack_inst;
    logic        pack_ok;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic        err_set;

    rv_enc_pack u_pack (
        .fmt    (in_fmt),
        .op     (in_op),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .inst   (pack_inst),
        .ok     (pack_ok)
    );

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign in_ready = rst_n && !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && pack_ok && !flush;
    assign err_set  = accept && !pack_ok && !flush;
    assign pop      = !empty && out_ready && !flush;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_inst  = out_valid ? head.inst : 32'h0;
    assign out_addr  = out_valid ? head.addr : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            addr_cnt <= BASE_ADDR;
            err      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                addr_cnt <= BASE_ADDR;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    addr_cnt <= addr_cnt + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            // A new error wins over a simultaneous clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{inst: pack_inst, addr: addr_cnt};
        end
    end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// tb/tb_rv_inst_encoder.sv - self-checking bench for rv_inst_encoder against a behavioural encoder/FIFO model
module tb_rv_inst_encoder;
    import rv_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_op = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        flush = 1'b0;
    logic        err;
    logic        err_clr = 1'b0;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_out_inst;
    logic [31:0] w_out_addr;
    logic        w_err;

    int n_vec = 0;
    int n_err = 0;

    bit [31:0] q_inst[$];
    bit [31:0] q_addr[$];
    bit [31:0] m_cnt;
    bit        m_err;

    always #5 clk = ~clk;

    rv_inst_encoder #(.BASE_ADDR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .flush(flush), .err(err), .err_clr(err_clr)
    );

    rv_inst_encoder #(.BASE_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_inst(w_out_inst), .out_addr(w_out_addr),
        .flush(flush), .err(w_err), .err_clr(err_clr)
    );

    // Reference encoder: fields placed by shift/mask arithmetic on the ISA layout.
    function automatic bit [31:0] ref_enc(input bit [2:0] f, input bit [6:0] op7, input bit [2:0] f3_3,
                                          input bit [6:0] f7_7, input bit [4:0] rd5, input bit [4:0] rs1_5,
                                          input bit [4:0] rs2_5, input bit [31:0] imm, output bit ok);
        bit [31:0] op = 32'(op7), f3 = 32'(f3_3), f7 = 32'(f7_7);
        bit [31:0] rd = 32'(rd5), rs1 = 32'(rs1_5), rs2 = 32'(rs2_5);
        int s = int'(imm);
        ok = 1'b1;
        case (f)
            RTYPE: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            ITYPE: begin
`ifdef ENC_RANGE_CHECK_EN
                ok = (s >= -2048) && (s <= 2047);
`endif
                return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            STYPE: begin
`ifdef ENC_RANGE_CHECK_EN
                ok = (s >= -2048) && (s <= 2047);
`endif
                return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                       | ((imm & 32'h1F) << 7) | op;
            end
            BTYPE: begin
`ifdef ENC_RANGE_CHECK_EN
                ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
`endif
                return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                       | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                       | (((imm >> 11) & 1) << 7) | op;
            end
            UTYPE: begin
`ifdef ENC_RANGE_CHECK_EN
                ok = (imm % 4096) == 0;
`endif
                return (imm & 32'hFFFF_F000) | (rd << 7) | op;
            end
            JTYPE: begin
`ifdef ENC_RANGE_CHECK_EN
                ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
`endif
                return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            end
            default: begin
                ok = 1'b0;
                return 32'h0;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        in_fmt = f; in_op = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
        n_vec++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL rst_out_inst got %h want 0", out_inst); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_rtype();
        out_ready = 1'b0;
        drive(RTYPE, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL r_valid got %b want 1", out_valid); end
        n_vec++; if (out_inst !== 32'h002081B3) begin n_err++; $display("FAIL r_inst got %h want 002081b3", out_inst); end
        n_vec++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL r_addr got %h want 0", out_addr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL r_idle_valid got %b want 0", out_valid); end
        n_vec++; if (out_inst !== 32'h0 || out_addr !== 32'h0) begin
            n_err++; $display("FAIL r_idle_zero got %h/%h want 0/0", out_inst, out_addr); end
    endtask

    task automatic test_i_u();
        do_flush();
        drive(ITYPE, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        tick();
        drive(UTYPE, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_inst !== 32'hFFF00093 || out_addr !== 32'h0) begin
            n_err++; $display("FAIL i_word got %h@%h want fff00093@0", out_inst, out_addr); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL i_full got %b want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if (out_inst !== 32'h123452B7 || out_addr !== 32'h4) begin
            n_err++; $display("FAIL u_word got %h@%h want 123452b7@4", out_inst, out_addr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_b_j();
        do_flush();
        drive(BTYPE, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        tick();
        drive(JTYPE, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_inst !== 32'hFE208EE3 || out_addr !== 32'h0) begin
            n_err++; $display("FAIL b_word got %h@%h want fe208ee3@0", out_inst, out_addr); end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_inst !== 32'h008000EF || out_addr !== 32'h4) begin
            n_err++; $display("FAIL j_word got %h@%h want 008000ef@4", out_inst, out_addr); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure_flush();
        bit [31:0] wa, wc;
        bit ok;
        wa = ref_enc(RTYPE, OP_REG, 3'd0, 7'd0, 5'd1, 5'd4, 5'd5, 32'h0, ok);
        wc = ref_enc(RTYPE, OP_REG, 3'd0, 7'd0, 5'd3, 5'd4, 5'd5, 32'h0, ok);
        do_flush();
        out_ready = 1'b0;
        drive(RTYPE, OP_REG, 3'd0, 7'd0, 5'd1, 5'd4, 5'd5, 32'h0);
        tick();
        drive(RTYPE, OP_REG, 3'd0, 7'd0, 5'd2, 5'd4, 5'd5, 32'h0);
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", in_ready); end
        drive(RTYPE, OP_REG, 3'd0, 7'd0, 5'd3, 5'd4, 5'd5, 32'h0);
        tick();
        n_vec++; if (out_inst !== wa || out_addr !== 32'h0) begin
            n_err++; $display("FAIL bp_hold got %h@%h want %h@0", out_inst, out_addr, wa); end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_addr !== 32'h4 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_no_pass got %h rdy %b want 4 rdy 1", out_addr, in_ready); end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_vec++; if (out_inst !== wc || out_addr !== 32'h8) begin
            n_err++; $display("FAIL bp_third got %h@%h want %h@8", out_inst, out_addr, wc); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        drive(RTYPE, OP_REG, 3'd0, 7'd0, 5'd1, 5'd4, 5'd5, 32'h0);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL flush_addr got %h want 0", out_addr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_range();
        do_flush();
        drive(ITYPE, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        n_vec++; if (err !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL range_rej got err %b valid %b want 1 0", err, out_valid); end
        drive(ITYPE, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_addr !== 32'h0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL range_addr got %h valid %b want 0 1", out_addr, out_valid); end
`else
        n_vec++; if (out_inst !== 32'h80000093 || err !== 1'b0) begin
            n_err++; $display("FAIL range_trunc got %h err %b want 80000093 0", out_inst, err); end
`endif
        out_ready = 1'b1;
        err_clr = 1'b1;
        tick();
        out_ready = 1'b0;
        err_clr = 1'b0;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL range_clr got %b want 0", err); end
    endtask

    task automatic test_invalid_reset();
        do_flush();
        drive(3'b111, OP_REG, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0);
        tick();
        in_valid = 1'b0;
        n_vec++; if (err !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL bad_fmt got err %b valid %b want 1 0", err, out_valid); end
        n_vec++; if (w_err !== 1'b1) begin n_err++; $display("FAIL bad_fmt_wrap got %b want 1", w_err); end
        drive(3'b110, OP_REG, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0);
        err_clr = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_clr_race got %b want 1", err); end
        tick();
        err_clr = 1'b0;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clr got %b want 0", err); end
        drive(RTYPE, OP_REG, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        tick();
        drive(RTYPE, OP_REG, 3'd0, 7'd0, 5'd4, 5'd2, 5'd3, 32'h0);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL async_rst got valid %b rdy %b want 0 0", out_valid, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(RTYPE, OP_REG, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL post_rst_addr got %h want 0", out_addr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_flush();
        out_ready = 1'b1;
        drive(RTYPE, OP_REG, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        tick();
        n_vec++; if (w_out_addr !== 32'hFFFF_FFF8 || w_out_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap0 got %h want fffffff8", w_out_addr); end
        tick();
        n_vec++; if (w_out_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap1 got %h want fffffffc", w_out_addr); end
        tick();
        in_valid = 1'b0;
        n_vec++; if (w_out_addr !== 32'h0 || w_out_inst !== 32'h003100B3) begin
            n_err++; $display("FAIL wrap2 got %h@%h want 003100b3@0", w_out_inst, w_out_addr); end
        tick();
        n_vec++; if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
            n_err++; $display("FAIL wrap_idle got valid %b rdy %b want 0 1", w_out_valid, w_in_ready); end
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int edge_imm[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                             1048574, 1048576, -1048576, 12288};
        bit [31:0] w;
        bit ok, acc, pop;
        do_flush();
        out_ready = 1'b1;
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        q_inst.delete();
        q_addr.delete();
        m_cnt = 32'h0;
        m_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            n_vec++; if (out_valid !== (q_inst.size() > 0)) begin
                n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, q_inst.size() > 0); end
            n_vec++; if (in_ready !== (q_inst.size() < DEPTH)) begin
                n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", i, in_ready, q_inst.size() < DEPTH); end
            n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err[%0d] got %b want %b", i, err, m_err); end
            n_vec++;
            if (q_inst.size() > 0) begin
                if (out_inst !== q_inst[0] || out_addr !== q_addr[0]) begin
                    n_err++; $display("FAIL rnd_word[%0d] got %h@%h want %h@%h", i, out_inst, out_addr, q_inst[0], q_addr[0]); end
            end else if (out_inst !== 32'h0 || out_addr !== 32'h0) begin
                n_err++; $display("FAIL rnd_idle[%0d] got %h@%h want 0@0", i, out_inst, out_addr);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_fmt    = 3'($urandom_range(0, 7));
            in_op     = 7'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            case ($urandom_range(0, 2))
                0:       in_imm = $urandom;
                1:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: in_imm = 32'(edge_imm[$urandom_range(0, 11)]);
            endcase
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            err_clr   = ($urandom_range(0, 7) == 0);
            w   = ref_enc(in_fmt, in_op, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, ok);
            acc = in_valid && (q_inst.size() < DEPTH);
            pop = out_ready && (q_inst.size() > 0);
            tick();
            if (flush) begin
                q_inst.delete();
                q_addr.delete();
                m_cnt = 32'h0;
            end else begin
                if (pop) begin
                    void'(q_inst.pop_front());
                    void'(q_addr.pop_front());
                end
                if (acc && ok) begin
                    q_inst.push_back(w);
                    q_addr.push_back(m_cnt);
                    m_cnt = m_cnt + 32'd4;
                end
            end
            if (acc && !ok && !flush) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        err_clr = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_i_u();
        test_b_j();
        test_backpressure_flush();
        test_range();
        test_invalid_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
